// File: rtl/wb_pkg.sv
// wb_pkg: shared definitions for the writeback stage.
//   res_src_e : ResultSrc encodings selecting the writeback source
//   entry_w() : packed width of one buffered {we, rd, data} entry
package wb_pkg;

  typedef enum logic [1:0] {
    RES_ALU  = 2'd0,
    RES_MEM  = 2'd1,
    RES_LINK = 2'd2,
    RES_IMM  = 2'd3
  } res_src_e;

  // The entry struct itself depends on ADDR_W/DATA_W, so each user declares
  // it locally as {we, rd, data}; this keeps the packed width in one place.
  function automatic int entry_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/wb_entry_fifo.sv
// wb_entry_fifo: DEPTH-entry circular buffer of writeback entries.
//   clk, reset        : clock, synchronous active-high reset
//   push, wdata       : enqueue (ignored when full)
//   pop               : dequeue head (ignored when empty)
//   full, empty       : from the occupancy counter
//   ent_vld, ent_data : entries in age order, [0] = head (oldest)
module wb_entry_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 12
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic                      pop,
  input  logic [W-1:0]              wdata,
  output logic                      full,
  output logic                      empty,
  output logic [DEPTH-1:0]          ent_vld,
  output logic [DEPTH-1:0][W-1:0]   ent_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           count;
  logic                    push_ok, pop_ok;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (pop_ok) rd_ptr <= nxt(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Rotate storage into age order so the forwarding search can simply
  // prefer the highest valid index as the youngest entry.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ord
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    always_comb begin
      sum = {1'b0, rd_ptr} + (PW+1)'(i);
      idx = (sum >= (PW+1)'(DEPTH)) ? PW'(sum - (PW+1)'(DEPTH)) : PW'(sum);
    end
    assign ent_data[i] = mem[idx];
    assign ent_vld[i]  = (CW'(i) < count);
  end

endmodule

// File: rtl/wb_stage_pipe.sv
// wb_stage_pipe: writeback stage. Selects/extends the result of each retiring
// instruction, buffers it, and drives the register-file write port, where a
// debug write has priority. Also forwards buffered results and counts retires.
//   clk, reset                     : clock, synchronous active-high reset
//   in_valid/in_ready              : handshake from MEM stage
//   RegWrite_in, ResultSrc_in, load_sext_in, *_in sources, rd_in : instruction
//   dbg_we, dbg_waddr, dbg_wdata   : debug write (wins the port)
//   rf_we, rf_waddr, rf_wdata      : register-file write port
//   fwd_rs -> fwd_hit, fwd_data    : youngest buffered match lookup
//   retire_cnt                     : pops since reset, wraps
module wb_stage_pipe
  import wb_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 3,
  parameter int LOAD_W  = 8,
  parameter int DEPTH   = 2,
  parameter int ZERO_RO = 0,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              RegWrite_in,
  input  logic [1:0]        ResultSrc_in,
  input  logic              load_sext_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] link_in,
  input  logic [DATA_W-1:0] imm_in,
  input  logic [ADDR_W-1:0] rd_in,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_waddr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [ADDR_W-1:0] fwd_rs,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  retire_cnt
);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  localparam int EW = entry_w(ADDR_W, DATA_W);

  logic [DATA_W-1:0]       load_mask, mem_ext, sel_data;
  wb_entry_t               push_ent, head;
  wb_entry_t [DEPTH-1:0]   ents;
  logic [DEPTH-1:0][EW-1:0] ent_data;
  logic [DEPTH-1:0]        ent_vld;
  logic                    full, empty, push, pop;

  // Mask of the low LOAD_W bits; all ones when LOAD_W == DATA_W, so the
  // extension below degenerates to a pass-through in that case.
  assign load_mask = {DATA_W{1'b1}} >> (DATA_W - LOAD_W);
  assign mem_ext   = (load_sext_in && mem_data_in[LOAD_W-1]) ?
                     (mem_data_in | ~load_mask) : (mem_data_in & load_mask);

  always_comb begin
    sel_data = alu_result_in;
    case (res_src_e'(ResultSrc_in))
      RES_ALU:  sel_data = alu_result_in;
      RES_MEM:  sel_data = mem_ext;
      RES_LINK: sel_data = link_in;
      RES_IMM:  sel_data = imm_in;
      default:  sel_data = alu_result_in;
    endcase
  end

  // Suppressed register-0 writes still occupy an entry so they retire in order.
  assign push_ent.we   = RegWrite_in && !((ZERO_RO != 0) && (rd_in == '0));
  assign push_ent.rd   = rd_in;
  assign push_ent.data = sel_data;

  assign in_ready = !full && !reset;
  assign push     = in_valid && in_ready;
  assign pop      = !empty && !dbg_we && !reset;

  wb_entry_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .wdata    (push_ent),
    .full     (full),
    .empty    (empty),
    .ent_vld  (ent_vld),
    .ent_data (ent_data)
  );

  assign ents = ent_data;
  assign head = ents[0];

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (!reset) begin
      if (dbg_we) begin
        rf_we    = 1'b1;
        rf_waddr = dbg_waddr;
        rf_wdata = dbg_wdata;
      end else if (!empty && head.we) begin
        rf_we    = 1'b1;
        rf_waddr = head.rd;
        rf_wdata = head.data;
      end
    end
  end

  // Later (younger) matches overwrite earlier ones.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_vld[i] && ents[i].we && (ents[i].rd == fwd_rs)) begin
          fwd_hit  = 1'b1;
          fwd_data = ents[i].data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)    retire_cnt <= '0;
    else if (pop) retire_cnt <= retire_cnt + 1'b1;
  end

endmodule

// File: tb/tb_wb_stage_pipe.sv
module tb_wb_stage_pipe;
  localparam int DW = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0, in_ready;
  logic          RegWrite_in = 1'b0;
  logic [1:0]    ResultSrc_in = 2'd0;
  logic          load_sext_in = 1'b0;
  logic [DW-1:0] alu_result_in = '0, mem_data_in = '0, link_in = '0, imm_in = '0;
  logic [AW-1:0] rd_in = '0;
  logic          dbg_we = 1'b0;
  logic [AW-1:0] dbg_waddr = '0;
  logic [DW-1:0] dbg_wdata = '0;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [AW-1:0] fwd_rs = '0;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic [3:0]    retire_cnt;

  int checks = 0;
  int failures = 0;
  int exp_ret = 0;
  int commit_n = 0;
  int cyc = 0;
  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] mon_e;

  wb_stage_pipe #(.DATA_W(16), .ADDR_W(3), .LOAD_W(8), .DEPTH(2), .ZERO_RO(1), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .RegWrite_in(RegWrite_in), .ResultSrc_in(ResultSrc_in), .load_sext_in(load_sext_in),
    .alu_result_in(alu_result_in), .mem_data_in(mem_data_in), .link_in(link_in),
    .imm_in(imm_in), .rd_in(rd_in), .dbg_we(dbg_we), .dbg_waddr(dbg_waddr),
    .dbg_wdata(dbg_wdata), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_rs(fwd_rs), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Scoreboard: every buffered commit must match the oldest expected write.
  always @(negedge clk) begin
    if (!reset && rf_we && !dbg_we) begin
      commit_n++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL commit_unexpected got addr=%0d data=%h, none expected", rf_waddr, rf_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if ({rf_waddr, rf_wdata} !== mon_e) begin
          failures++;
          $display("FAIL commit got addr=%0d data=%h want addr=%0d data=%h",
                   rf_waddr, rf_wdata, mon_e[DW+AW-1:DW], mon_e[DW-1:0]);
        end
      end
    end
  end

  // Present one instruction until accepted. The bench's own model of the
  // selected/extended value goes to the scoreboard at the accepting edge.
  task automatic send(input logic [1:0] src, input logic sext, input logic rw,
                      input logic [AW-1:0] rd, input logic [DW-1:0] val, input bit track);
    logic [DW-1:0] exp_d;
    bit ok = 0;
    in_valid      = 1'b1;
    RegWrite_in   = rw;
    ResultSrc_in  = src;
    load_sext_in  = sext;
    rd_in         = rd;
    alu_result_in = (src == 2'd0) ? val : 16'hDEAD;
    mem_data_in   = (src == 2'd1) ? {8'h5A, val[7:0]} : 16'hBEEF;
    link_in       = (src == 2'd2) ? val : 16'hCAFE;
    imm_in        = (src == 2'd3) ? val : 16'hF00D;
    case (src)
      2'd1:    exp_d = (sext && val[7]) ? {8'hFF, val[7:0]} : {8'h00, val[7:0]};
      default: exp_d = val;
    endcase
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        if (track) begin
          exp_ret++;
          if (rw && rd != 0) exp_q.push_back({rd, exp_d});
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++; failures++;
      $display("FAIL accept_timeout rd=%0d never accepted", rd);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL rst_rf_we got %b want 0", rf_we); end
    checks++; if (retire_cnt !== 4'd0) begin failures++; $display("FAIL rst_retire got %0d want 0", retire_cnt); end
    checks++; if (fwd_hit !== 1'b0 || fwd_data !== 16'h0) begin failures++; $display("FAIL rst_fwd got %b/%h want 0/0", fwd_hit, fwd_data); end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_rst_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    send(2'd0, 1'b0, 1'b1, 3'd5, 16'h003C, 1);
    send(2'd1, 1'b0, 1'b1, 3'd2, 16'h0081, 1);
    repeat (4) @(posedge clk); #1;
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL basic_drain got %0d pending want 0", exp_q.size()); end
    checks++; if (retire_cnt !== 4'(exp_ret)) begin failures++; $display("FAIL basic_retire got %0d want %0d", retire_cnt, exp_ret % 16); end
  endtask

  task automatic test_ext();
    send(2'd1, 1'b1, 1'b1, 3'd1, 16'h0081, 1);
    send(2'd1, 1'b0, 1'b1, 3'd2, 16'h0081, 1);
    send(2'd0, 1'b1, 1'b1, 3'd3, 16'h0081, 1);
    send(2'd1, 1'b1, 1'b1, 3'd4, 16'h007F, 1);
    send(2'd2, 1'b0, 1'b1, 3'd6, 16'h1234, 1);
    send(2'd3, 1'b1, 1'b1, 3'd7, 16'h8765, 1);
    repeat (4) @(posedge clk); #1;
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL ext_drain got %0d pending want 0", exp_q.size()); end
    checks++; if (retire_cnt !== 4'(exp_ret)) begin failures++; $display("FAIL ext_retire got %0d want %0d", retire_cnt, exp_ret % 16); end
  endtask

  task automatic test_debug();
    logic [DW-1:0] vals [3] = '{16'h0101, 16'h0202, 16'h0303};
    int idx = 0;
    dbg_we = 1'b1; dbg_waddr = 3'd7; dbg_wdata = 16'h00AA;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1; RegWrite_in = 1'b1; ResultSrc_in = 2'd0;
      rd_in = 3'(idx + 1); alu_result_in = vals[idx];
      @(negedge clk);
      checks++;
      if (rf_we !== 1'b1 || rf_waddr !== 3'd7 || rf_wdata !== 16'h00AA) begin
        failures++;
        $display("FAIL dbg_port got %b/%0d/%h want 1/7/00aa", rf_we, rf_waddr, rf_wdata);
      end
      if (in_ready && idx < 3) begin
        exp_q.push_back({3'(idx + 1), vals[idx]});
        exp_ret++;
        idx++;
      end
      @(posedge clk); #1;
    end
    checks++; if (idx != 2) begin failures++; $display("FAIL dbg_accepts got %0d want 2", idx); end
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL dbg_full_ready got %b want 0", in_ready); end
    @(posedge clk); #1;
    dbg_we = 1'b0;
    send(2'd0, 1'b0, 1'b1, 3'd3, 16'h0303, 1);
    repeat (4) @(posedge clk); #1;
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL dbg_drain got %0d pending want 0", exp_q.size()); end
    checks++; if (retire_cnt !== 4'(exp_ret)) begin failures++; $display("FAIL dbg_retire got %0d want %0d", retire_cnt, exp_ret % 16); end
  endtask

  task automatic test_fwd();
    dbg_we = 1'b1; dbg_waddr = 3'd1; dbg_wdata = 16'h0055;
    send(2'd0, 1'b0, 1'b1, 3'd4, 16'h0011, 1);
    fwd_rs = 3'd4; #1;
    checks++; if (fwd_hit !== 1'b1 || fwd_data !== 16'h0011) begin failures++; $display("FAIL fwd_one got %b/%h want 1/0011", fwd_hit, fwd_data); end
    send(2'd0, 1'b0, 1'b1, 3'd4, 16'h0022, 1);
    fwd_rs = 3'd4; #1;
    checks++; if (fwd_hit !== 1'b1 || fwd_data !== 16'h0022) begin failures++; $display("FAIL fwd_young got %b/%h want 1/0022", fwd_hit, fwd_data); end
    fwd_rs = 3'd3; #1;
    checks++; if (fwd_hit !== 1'b0 || fwd_data !== 16'h0000) begin failures++; $display("FAIL fwd_miss got %b/%h want 0/0000", fwd_hit, fwd_data); end
    @(posedge clk); #1;
    dbg_we = 1'b0;
    repeat (4) @(posedge clk); #1;
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL fwd_drain got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_zero();
    int n0 = commit_n;
    int r0 = exp_ret;
    send(2'd0, 1'b0, 1'b1, 3'd0, 16'h0055, 1);
    send(2'd0, 1'b0, 1'b0, 3'd3, 16'h0066, 1);
    repeat (4) @(posedge clk); #1;
    checks++; if (commit_n != n0) begin failures++; $display("FAIL zero_no_write got %0d writes want 0", commit_n - n0); end
    checks++; if (retire_cnt !== 4'(r0 + 2)) begin failures++; $display("FAIL zero_retire got %0d want %0d", retire_cnt, (r0 + 2) % 16); end
  endtask

  task automatic test_reset_mid();
    int n0 = commit_n;
    dbg_we = 1'b1; dbg_waddr = 3'd2; dbg_wdata = 16'h0077;
    send(2'd0, 1'b0, 1'b1, 3'd5, 16'h0aaa, 0);
    send(2'd0, 1'b0, 1'b1, 3'd6, 16'h0bbb, 0);
    fwd_rs = 3'd5; #1;
    checks++; if (fwd_hit !== 1'b1) begin failures++; $display("FAIL rmid_pre_hit got %b want 1", fwd_hit); end
    reset = 1'b1; dbg_we = 1'b0;
    @(negedge clk);
    checks++; if (rf_we !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL rmid_during got we=%b rdy=%b want 0/0", rf_we, in_ready); end
    @(posedge clk); #1;
    reset = 1'b0; exp_ret = 0; #1;
    checks++; if (fwd_hit !== 1'b0) begin failures++; $display("FAIL rmid_fwd got %b want 0", fwd_hit); end
    checks++; if (retire_cnt !== 4'd0) begin failures++; $display("FAIL rmid_retire got %0d want 0", retire_cnt); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rmid_ready got %b want 1", in_ready); end
    repeat (4) @(posedge clk); #1;
    checks++; if (commit_n != n0) begin failures++; $display("FAIL rmid_no_write got %0d writes want 0", commit_n - n0); end
  endtask

  task automatic test_back_to_back();
    int c0 = cyc;
    for (int i = 0; i < 17; i++) send(2'd0, 1'b0, 1'b1, 3'(1 + i % 7), 16'(16'h0100 + i), 1);
    checks++; if (cyc - c0 != 17) begin failures++; $display("FAIL b2b_cycles got %0d want 17", cyc - c0); end
    repeat (4) @(posedge clk); #1;
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_drain got %0d pending want 0", exp_q.size()); end
    checks++; if (retire_cnt !== 4'd1) begin failures++; $display("FAIL b2b_wrap got %0d want 1", retire_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ext();
    test_debug();
    test_fwd();
    test_zero();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
